imem_loader: RTL

- Writer side of the instruction memory: receives a program image as a byte stream and writes it as 32-bit words into the instruction memory write port.
- Holds the CPU (PC advance, register writeback) until the image is fully committed.
- Sits between the host/bench byte source and InstructionMemory; the CPU remains the only reader.

---
 rtl/imem_loader.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// imem_loader
//   Writer side of the instruction memory. Receives a program image as a
//   byte stream (16-bit little-endian word count N, then 4*N data bytes,
//   little-endian within each word) and writes it as 32-bit words through
//   the instruction memory write port. The CPU is held until the image is
//   fully committed.
//
// Optional feature (compile-time macro IMEM_LOADER_CHECKSUM_EN):
//   After the last data byte one extra byte is accepted. The load completes
//   only if it equals the XOR of all 4*N data bytes; otherwise the load ends
//   in ERROR. A zero-length image never takes a checksum byte.
//
// Parameters:
//   ADDR_WIDTH  word-address bits of instruction memory (2^ADDR_WIDTH words)
//   BASE_ADDR   byte address of the first loaded word (4-byte aligned)
//
// Ports:
//   clk                rising-edge system clock
//   reset              synchronous, active-high
//   start              begin a load (honoured only in IDLE, DONE, ERROR)
//   byte_data          stream byte
//   byte_valid         byte_data is valid
//   byte_ready         loader accepts a byte this cycle (function of state)
//   mem_write_enable   one-cycle write strobe
//   mem_write_address  byte address of the write
//   mem_write_data     word to write
//   cpu_hold           stall the CPU while high
//   busy               load in progress
//   done               image committed
//   error              load aborted (sticky until start or reset)
//   words_loaded       words written in the current load

module imem_loader #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            byte_data,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic                  mem_write_enable,
  output logic [31:0]           mem_write_address,
  output logic [31:0]           mem_write_data,
  output logic                  cpu_hold,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   words_loaded
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    IDLE, LEN_LO, LEN_HI, DATA, CHECK, DONE, ERROR
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, LEN_LO, LEN_HI, DATA, DONE, ERROR
  } state_t;
`endif

  // Largest image that fits: 2^ADDR_WIDTH words. Held in 33 bits so the
  // comparison against the 16-bit length is well defined for any width.
  localparam logic [32:0] MAX_WORDS = 33'd1 << ADDR_WIDTH;

  state_t state;
  state_t state_next;

  logic [7:0]           len_lo;      // low length byte, held until LEN_HI
  logic [15:0]          len_n;       // full length as seen during LEN_HI
  logic                 len_too_big;
  logic [15:0]          rem_words;   // words still to come after the current one
  logic [1:0]           byte_sel;    // byte position within the current word
  logic [23:0]          word_buf;    // first three bytes of the current word
  logic [ADDR_WIDTH:0]  word_count;
  logic                 accept;
  logic                 start_load;
  logic                 word_complete;
  logic                 last_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]           csum;
`endif

  assign accept        = byte_valid && byte_ready;
  assign start_load    = start && ((state == IDLE) || (state == DONE) || (state == ERROR));
  assign len_n         = {byte_data, len_lo};
  assign len_too_big   = {17'd0, len_n} > MAX_WORDS;
  assign word_complete = accept && (state == DATA) && (byte_sel == 2'd3);
  assign last_word     = (rem_words == 16'd0);

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------
  // Next state and state-decoded outputs.
  // In every state where byte_ready is 1, byte_valid alone means a transfer.
  // ---------------------------------------------------------------------
  always_comb begin
    state_next = state;
    byte_ready = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    error      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_next = LEN_LO;
      end
      LEN_LO: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (byte_valid) state_next = LEN_HI;
      end
      LEN_HI: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (byte_valid) begin
          if (len_n == 16'd0)   state_next = DONE;
          else if (len_too_big) state_next = ERROR;
          else                  state_next = DATA;
        end
      end
      DATA: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (word_complete && last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_next = CHECK;
`else
          state_next = DONE;
`endif
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHECK: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (byte_valid) state_next = (byte_data == csum) ? DONE : ERROR;
      end
`endif
      DONE: begin
        done = 1'b1;
        if (start) state_next = LEN_LO;
      end
      ERROR: begin
        error = 1'b1;
        if (start) state_next = LEN_LO;
      end
      default: state_next = IDLE;
    endcase
  end

  // The final write pulse lands in the first DONE cycle, so the CPU is
  // released one cycle after the last word reaches memory.
  assign cpu_hold     = (state != DONE) || mem_write_enable;
  assign words_loaded = word_count;

  // ---------------------------------------------------------------------
  // Datapath: length capture, word assembly, write port, counters.
  // Reset has priority over a write that would otherwise be issued on the
  // same edge, so an interrupted load never produces a late pulse.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      len_lo            <= '0;
      rem_words         <= '0;
      byte_sel          <= '0;
      word_buf          <= '0;
      word_count        <= '0;
      mem_write_enable  <= 1'b0;
      mem_write_address <= '0;
      mem_write_data    <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum              <= '0;
`endif
    end else begin
      mem_write_enable <= 1'b0;

      if (start_load) begin
        rem_words  <= '0;
        byte_sel   <= '0;
        word_count <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum       <= '0;
`endif
      end

      if (accept) begin
        case (state)
          LEN_LO: len_lo <= byte_data;
          LEN_HI: rem_words <= len_n - 16'd1;
          DATA: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum <= csum ^ byte_data;
`endif
            byte_sel <= byte_sel + 2'd1;
            if (byte_sel == 2'd3) begin
              // Address comes from the pre-increment count, i.e. word i.
              mem_write_enable  <= 1'b1;
              mem_write_address <= BASE_ADDR + (32'(word_count) << 2);
              mem_write_data    <= {byte_data, word_buf};
              word_count        <= word_count + 1'b1;
              rem_words         <= rem_words - 16'd1;
            end else begin
              // Shift in from the top: after three bytes the first one
              // received sits in bits 7:0.
              word_buf <= {byte_data, word_buf[23:8]};
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
